// File: rtl/mfda_pump_pkg.sv
// Shared types and constants for the Source-inlet pump dispenser.
package mfda_pump_pkg;

    // Controller states; also exported on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_PUMP  = 3'd2,
        ST_DWELL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Number of valve phases in one peristaltic stroke.
    localparam int PUMP_PHASES = 6;

    // Valve polarity: a 1 on a pump valve actuates (closes) it, a 1 on the
    // inlet opens the Source inlet.
    localparam logic [2:0] VALVES_RELEASED = 3'b000;
    localparam logic       INLET_OPEN      = 1'b1;
    localparam logic       INLET_SHUT      = 1'b0;

    // Phase patterns, bit0 is the inlet-side valve. Entry [0] is the first phase.
    localparam logic [PUMP_PHASES-1:0][2:0] PHASE_PATTERN = {
        3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
    };

endpackage

// File: rtl/pump_phase_gen.sv
// Phase timer for the peristaltic pump: holds each of the six phases for
// PHASE_CYCLES cycles while enabled and flags the last cycle of each stroke.
module pump_phase_gen
    import mfda_pump_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [2:0] next_pattern,
    output logic       stroke_tick
);

    localparam int               TMR_W      = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(PHASE_CYCLES - 1);
    localparam logic [2:0]       PHASE_LAST = 3'(PUMP_PHASES - 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       phase_q, phase_d;

    // Advance the position while enabled; park at phase 0 otherwise so the
    // next pump run always starts on the first pattern.
    always_comb begin
        timer_d     = '0;
        phase_d     = '0;
        stroke_tick = 1'b0;
        if (enable) begin
            if (timer_q == TMR_LAST) begin
                timer_d = '0;
                if (phase_q == PHASE_LAST) begin
                    phase_d     = '0;
                    stroke_tick = 1'b1;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end else begin
                timer_d = timer_q + TMR_W'(1);
                phase_d = phase_q;
            end
        end
    end

    // Pattern of the position the counters hold after this edge; the owner
    // registers it so the valve outputs line up with the controller state.
    assign next_pattern = PHASE_PATTERN[phase_d];

    // Position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            phase_q <= '0;
        end else begin
            timer_q <= timer_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/mfda_source_dispenser.sv
// Source-inlet dispenser: accepts a stroke/dwell command, primes the inlet,
// runs the peristaltic pump, holds for the mixing dwell and pulses done.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high exactly in IDLE, and the command
// fields are sampled only on that edge.
module mfda_source_dispenser
    import mfda_pump_pkg::*;
#(
    parameter int PHASE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int STROKE_W      = 8,
    parameter int HOLD_W        = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STROKE_W-1:0] cmd_strokes,
    input  logic [HOLD_W-1:0]   cmd_hold,
    input  logic                abort,
    output logic [2:0]          pump_valve,
    output logic                inlet_valve,
    output logic                busy,
    output logic                done,
    output logic [STROKE_W-1:0] strokes_done,
    output state_t              dbg_state
);

    localparam int CNT_W = (HOLD_W > $clog2(SETTLE_CYCLES + 1)) ? HOLD_W : $clog2(SETTLE_CYCLES + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STROKE_W-1:0] strokes_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                accept;
    logic                stroke_inc;
    logic [2:0]          next_pattern;
    logic                stroke_tick;

    pump_phase_gen #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_phase (
        .clk         (clk),
        .rst         (rst),
        .enable      (state_q == ST_PUMP),
        .next_pattern(next_pattern),
        .stroke_tick (stroke_tick)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign dbg_state = state_q;

    // Next-state logic; cnt counts cycles spent in PRIME and DWELL.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        accept     = 1'b0;
        stroke_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = (cmd_strokes == '0) ? ST_DONE : ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (abort) state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_PUMP;
            end
            ST_PUMP: begin
                cnt_d = '0;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (stroke_tick) begin
                    stroke_inc = 1'b1;
                    if (strokes_done + STROKE_W'(1) == strokes_q)
                        state_d = (hold_q == '0) ? ST_DONE : ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (abort) state_d = ST_IDLE;
                else if (cnt_q == CNT_W'(hold_q) - CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // State, counters and the latched command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            strokes_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                strokes_q <= cmd_strokes;
                hold_q    <= cmd_hold;
            end
        end
    end

    // Registered outputs, decoded from the state being entered so they line
    // up with it; an abort clears them on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pump_valve   <= VALVES_RELEASED;
            inlet_valve  <= INLET_SHUT;
            busy         <= 1'b0;
            done         <= 1'b0;
            strokes_done <= '0;
        end else begin
            pump_valve  <= (state_d == ST_PUMP) ? next_pattern : VALVES_RELEASED;
            inlet_valve <= (state_d == ST_PRIME || state_d == ST_PUMP) ? INLET_OPEN : INLET_SHUT;
            busy        <= (state_d == ST_PRIME || state_d == ST_PUMP || state_d == ST_DWELL);
            done        <= (state_d == ST_DONE);
            if (accept) strokes_done <= '0;
            else if (stroke_inc) strokes_done <= strokes_done + STROKE_W'(1);
        end
    end

endmodule
